// File: rtl/sp_ram_ctrl_if.sv
// Request/response handshake between a client and sp_ram_ctrl.
// The master modport is the client side; the slave modport is the controller side.
interface sp_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 24
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sp_ram_ctrl.sv
// Valid/ready front end for single_port_sync_ram: 1-cycle writes, 3-cycle reads (one per 2 cycles).
// req_ready drops only while the RAM address phase of a read is in flight; responses are not backpressured.
module sp_ram_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sp_ram_ctrl_if.slave          bus,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);
  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_err;
  logic                  in_range;

  assign in_range      = {1'b0, bus.req_addr} < DEPTH_LIM;
  assign bus.req_ready = (state != RD_ADDR);
  // The bus is only ever driven while the RAM is being written, so oe/we never overlap.
  assign ram_data      = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ram_cs        <= 1'b0;
      ram_we        <= 1'b0;
      ram_oe        <= 1'b0;
      ram_addr      <= '0;
      wdata_q       <= '0;
      rd_err        <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (state == RD_ADDR) begin
        state  <= RD_DATA;
        ram_oe <= ~rd_err;
      end else begin
        if (state == RD_DATA) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= rd_err;
          bus.rsp_rdata <= rd_err ? '0 : ram_data;
        end
        ram_oe <= 1'b0;
        if (bus.req_valid) begin
          ram_addr <= bus.req_addr;
          if (bus.req_we) begin
            // Out-of-range writes are swallowed here and never reach the RAM.
            state   <= in_range ? WR : IDLE;
            ram_cs  <= in_range;
            ram_we  <= in_range;
            wdata_q <= bus.req_wdata;
          end else begin
            state  <= RD_ADDR;
            ram_cs <= in_range;
            ram_we <= 1'b0;
            rd_err <= ~in_range;
          end
        end else begin
          state  <= IDLE;
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Self-checking bench for sp_ram_ctrl: behavioural RAM on the pin side, queue-based
// reference model of memory contents and response timing on the client side.
module tb_sp_ram_ctrl;
  localparam int AW    = 5;
  localparam int DW    = 24;
  localparam int DEPTH = 20;
  localparam int WORDS = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sp_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // Pin-level RAM: registered read, oe-gated output; probe lets the bench own the bus.
  logic [DW-1:0] ram_mem [WORDS];
  logic [DW-1:0] ram_q;
  logic          probe = 1'b0;
  logic [DW-1:0] probe_val = 24'h5A5A5A;
  assign ram_data = probe ? probe_val : ((ram_cs && ram_oe && !ram_we) ? ram_q : 'z);
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr] <= ram_data;
      else        ram_q <= ram_mem[ram_addr];
    end
  end

  typedef struct packed {
    int unsigned   cyc;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  rsp_t          exp_q[$];
  rsp_t          obs_q[$];
  int unsigned   acc_q[$];
  logic [DW-1:0] ref_mem [WORDS];
  int unsigned   cyc = 0;
  int            we_cycles = 0;
  int            cs_cycles = 0;
  int            bus_viol = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  // Reference model: acceptance at edge N, read result visible in the cycle after edge N+2.
  always @(posedge clk) begin
    rsp_t e;
    cyc = cyc + 1;
    if (!rst && bus.req_valid && bus.req_ready) begin
      acc_q.push_back(cyc);
      if (bus.req_we) begin
        if (int'(bus.req_addr) < DEPTH) ref_mem[bus.req_addr] = bus.req_wdata;
      end else begin
        e.cyc  = cyc + 2;
        e.err  = (int'(bus.req_addr) >= DEPTH);
        e.data = e.err ? '0 : ref_mem[bus.req_addr];
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    rsp_t r;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.rsp_valid) begin
        r.cyc  = cyc;
        r.data = bus.rsp_rdata;
        r.err  = bus.rsp_err;
        obs_q.push_back(r);
      end
      if (ram_we) we_cycles++;
      if (ram_cs) cs_cycles++;
      if (ram_we && ram_oe) bus_viol++;
      if ((ram_we || (ram_cs && ram_oe)) && $isunknown(ram_data)) bus_viol++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    acc_q.delete();
  endtask

  // Called in the low phase; returns at the negedge after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    while (bus.req_ready !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (t == 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout addr=%0d ready stuck at %b, want 1", addr, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    n_checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl got %b want 000", {ram_cs, ram_we, ram_oe}); end
    n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL rst_addr got %h want 0", ram_addr); end
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== '0) begin n_fail++; $display("FAIL rst_rsp got v=%b e=%b d=%h want all 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    probe = 1'b1;
    #1;
    n_checks++; if (ram_data !== probe_val) begin n_fail++; $display("FAIL rst_bus_hiz got %h want %h", ram_data, probe_val); end
    probe = 1'b0;
    @(negedge clk) rst = 1'b0;
    // Mid-cycle reset while a write is on the bus.
    issue(1'b1, 5'd9, 24'h123456);
    n_checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b110) begin n_fail++; $display("FAIL wr_ctl got %b want 110", {ram_cs, ram_we, ram_oe}); end
    n_checks++; if (ram_addr !== 5'd9 || ram_data !== 24'h123456) begin n_fail++; $display("FAIL wr_bus got a=%0d d=%h want a=9 d=123456", ram_addr, ram_data); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({ram_cs, ram_we, ram_oe, bus.req_ready} !== 4'b0001) begin n_fail++; $display("FAIL rst_async got cs/we/oe/rdy=%b want 0001", {ram_cs, ram_we, ram_oe, bus.req_ready}); end
    probe = 1'b1;
    #1;
    n_checks++; if (ram_data !== probe_val) begin n_fail++; $display("FAIL rst_async_hiz got %h want %h", ram_data, probe_val); end
    probe = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_write_read();
    idle(1);
    clear_q();
    issue(1'b1, 5'd3, 24'hABCDEF);
    issue(1'b0, 5'd3, '0);
    idle(6);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL wrrd_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() == 1 && acc_q.size() == 2) begin
      n_checks++; if (obs_q[0].cyc != acc_q[1] + 2) begin n_fail++; $display("FAIL wrrd_latency got edge %0d want %0d", obs_q[0].cyc, acc_q[1] + 2); end
      n_checks++; if (obs_q[0].data !== 24'hABCDEF || obs_q[0].err !== 1'b0) begin n_fail++; $display("FAIL wrrd_data got %h err=%b want abcdef err=0", obs_q[0].data, obs_q[0].err); end
    end
  endtask

  task automatic test_back_to_back();
    int w0, bad;
    idle(1);
    clear_q();
    w0 = we_cycles;
    for (int a = 0; a < WORDS; a++) issue(1'b1, AW'(a), DW'(a) * 24'h010101);
    idle(2);
    bad = 0;
    for (int i = 1; i < acc_q.size(); i++) if (acc_q[i] != acc_q[i-1] + 1) bad++;
    n_checks++; if (bad != 0 || acc_q.size() != WORDS) begin n_fail++; $display("FAIL stream_wr_rate got %0d gaps over %0d accepts want 0 over %0d", bad, acc_q.size(), WORDS); end
    n_checks++; if (we_cycles - w0 != DEPTH) begin n_fail++; $display("FAIL stream_wr_cycles got %0d want %0d", we_cycles - w0, DEPTH); end
    clear_q();
    for (int a = 0; a < WORDS; a++) issue(1'b0, AW'(a), '0);
    idle(6);
    bad = 0;
    for (int i = 1; i < acc_q.size(); i++) if (acc_q[i] != acc_q[i-1] + 2) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stream_rd_rate got %0d bad spacings want 0", bad); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stream_rsp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stream_rsp[%0d] got edge=%0d d=%h e=%b want edge=%0d d=%h e=%b", i, obs_q[i].cyc, obs_q[i].data, obs_q[i].err, exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
      end
    end
    if (obs_q.size() > 10) begin
      n_checks++; if (obs_q[10].data !== 24'h0A0A0A) begin n_fail++; $display("FAIL stream_addr10 got %h want 0a0a0a", obs_q[10].data); end
    end
  endtask

  task automatic test_rd_then_wr();
    int v0;
    idle(1);
    clear_q();
    v0 = bus_viol;
    issue(1'b1, 5'd7, 24'h000111);
    issue(1'b0, 5'd7, '0);
    issue(1'b1, 5'd7, 24'h222222);
    issue(1'b0, 5'd7, '0);
    idle(6);
    n_checks++; if (acc_q.size() != 4 || acc_q[2] != acc_q[1] + 2) begin n_fail++; $display("FAIL rdwr_accept got %0d accepts, wr spacing bad, want 4 with wr 2 after rd", acc_q.size()); end
    n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL rdwr_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_checks++; if (obs_q[0].data !== 24'h000111) begin n_fail++; $display("FAIL rdwr_old got %h want 000111", obs_q[0].data); end
      n_checks++; if (obs_q[1].data !== 24'h222222) begin n_fail++; $display("FAIL rdwr_new got %h want 222222", obs_q[1].data); end
    end
    n_checks++; if (bus_viol != v0) begin n_fail++; $display("FAIL rdwr_bus got %0d violations want 0", bus_viol - v0); end
  endtask

  task automatic test_out_of_range();
    int c0;
    idle(1);
    clear_q();
    c0 = cs_cycles;
    issue(1'b0, 5'd25, '0);
    idle(5);
    n_checks++; if (cs_cycles != c0) begin n_fail++; $display("FAIL oor_rd_cs got %0d cs cycles want 0", cs_cycles - c0); end
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL oor_rd_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      n_checks++; if (obs_q[0].err !== 1'b1 || obs_q[0].data !== '0) begin n_fail++; $display("FAIL oor_rd_rsp got err=%b d=%h want err=1 d=0", obs_q[0].err, obs_q[0].data); end
    end
    c0 = cs_cycles;
    issue(1'b1, 5'd25, 24'hFFFFFF);
    idle(3);
    n_checks++; if (cs_cycles != c0) begin n_fail++; $display("FAIL oor_wr_cs got %0d cs cycles want 0", cs_cycles - c0); end
    clear_q();
    for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), '0);
    idle(6);
    n_checks++; if (obs_q.size() != DEPTH) begin n_fail++; $display("FAIL oor_readback_count got %0d want %0d", obs_q.size(), DEPTH); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL oor_readback[%0d] got d=%h e=%b want d=%h e=%b", i, obs_q[i].data, obs_q[i].err, exp_q[i].data, exp_q[i].err);
      end
    end
  endtask

  task automatic test_reset_rd_data();
    idle(1);
    clear_q();
    issue(1'b0, 5'd4, '0);
    @(negedge clk);
    n_checks++; if ({ram_cs, ram_oe, ram_we} !== 3'b110) begin n_fail++; $display("FAIL rdd_phase got cs/oe/we=%b want 110", {ram_cs, ram_oe, ram_we}); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({ram_cs, ram_oe, ram_we, bus.req_ready} !== 4'b0001) begin n_fail++; $display("FAIL rdd_rst got cs/oe/we/rdy=%b want 0001", {ram_cs, ram_oe, ram_we, bus.req_ready}); end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    idle(3);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rdd_no_rsp got %0d responses want 0", obs_q.size()); end
    clear_q();
    issue(1'b0, 5'd4, '0);
    idle(5);
    n_checks++; if (obs_q.size() != 1 || exp_q.size() != 1) begin n_fail++; $display("FAIL rdd_after got %0d responses want 1", obs_q.size()); end
    else begin
      n_checks++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rdd_after_rsp got d=%h e=%b want d=%h e=%b", obs_q[0].data, obs_q[0].err, exp_q[0].data, exp_q[0].err); end
    end
  endtask

  task automatic test_random();
    int v0;
    idle(1);
    clear_q();
    v0 = bus_viol;
    for (int i = 0; i < 80; i++) begin
      idle($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, WORDS - 1)), DW'($urandom));
    end
    idle(6);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d] got edge=%0d d=%h e=%b want edge=%0d d=%h e=%b", i, obs_q[i].cyc, obs_q[i].data, obs_q[i].err, exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
      end
    end
    n_checks++; if (bus_viol != v0) begin n_fail++; $display("FAIL rand_bus got %0d violations want 0", bus_viol - v0); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rd_then_wr();
    test_out_of_range();
    test_reset_rd_data();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete by time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
